data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 46 ++++
 rtl/bram_be.sv | 32 +++
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_data_mem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data memory responder: access-size codes, FSM states,
// the latched request record and byte-lane helpers.
package mem_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } req_t;

  // Byte-lane enables for an access of the given size starting at lane lo.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = 4'b0011 << {lo[1], 1'b0};
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      SZ_BYTE: m = 32'h0000_00FF;
      SZ_HALF: m = 32'h0000_FFFF;
      SZ_WORD: m = 32'hFFFF_FFFF;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Read-before-write on the same address; contents are never reset.
module bram_be #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-lane write and synchronous read.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i_we[i]) begin
          mem_q[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
      rdata_q <= mem_q[i_addr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder in front of a byte-enabled RAM.
// Accept in IDLE, touch RAM in ACCESS, present a held response in RESP.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_memsize,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err
);

  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic        accept_s;
  logic [1:0]  lo_s;
  logic        misalign_s;
  logic        err_s;
  logic [3:0]  be_s;
  logic [31:0] lane_wdata_s;
  logic        mem_en_s;
  logic [3:0]  mem_we_s;
  logic [31:0] mem_rdata_s;
  logic [31:0] load_data_s;

  assign accept_s = i_req_valid & req_ready_q;

  // State and registered-output flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_ACCESS;
        else          state_d = ST_IDLE;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_valid_q && i_rsp_ready) state_d = ST_IDLE;
        else                            state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Error and lane decode from the latched request.
  always_comb begin
    lo_s         = req_q.addr[1:0];
    misalign_s   = ((req_q.size == SZ_HALF) && lo_s[0]) ||
                   ((req_q.size == SZ_WORD) && (lo_s != 2'b00));
    err_s        = (req_q.size == SZ_NONE) || misalign_s ||
                   ({2'b00, req_q.addr[31:2]} >= DEPTH_L);
    be_s         = lane_be(req_q.size, lo_s);
    lane_wdata_s = req_q.wdata << {lo_s, 3'b000};
    load_data_s  = (mem_rdata_s >> {lo_s, 3'b000}) & size_mask(req_q.size);
  end

  // Outputs: request capture, RAM control and response formation.
  always_comb begin
    req_d       = req_q;
    req_ready_d = (state_d == ST_IDLE);
    mem_en_s    = 1'b0;
    mem_we_s    = 4'b0000;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    if (accept_s) begin
      req_d = '{write: i_write, addr: i_addr, wdata: i_wdata, size: i_memsize};
    end else begin
      req_d = req_q;
    end

    if ((state_q == ST_ACCESS) && !err_s && !i_rst) begin
      mem_en_s = 1'b1;
      mem_we_s = req_q.write ? be_s : 4'b0000;
    end else begin
      mem_en_s = 1'b0;
      mem_we_s = 4'b0000;
    end

    // RAM data lands during the first RESP cycle; publish it on the next edge.
    if ((state_q == ST_RESP) && !rsp_valid_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_s;
      rsp_data_d  = (err_s || req_q.write) ? 32'h0000_0000 : load_data_s;
    end else if (rsp_valid_q && i_rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_data_d  = 32'h0000_0000;
    end else begin
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_data_d  = rsp_data_q;
    end
  end

  bram_be #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_bram (
    .i_clk   (i_clk),
    .i_en    (mem_en_s),
    .i_we    (mem_we_s),
    .i_addr  (req_q.addr[AW+1:2]),
    .i_wdata (lane_wdata_s),
    .o_rdata (mem_rdata_s)
  );

  assign o_req_ready = req_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a vector table of load/store transactions
// plus hand-written reset, backpressure and latency sequences.
module tb_data_mem_responder;
  import mem_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_write = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic [1:0]  i_memsize = 2'b00;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH_WORDS(1024)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_write     (i_write),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_memsize   (i_memsize),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request and returns #1 after its accepting edge.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int n = 0;
    while (!o_req_ready && n < 20) begin
      @(posedge i_clk); #1;
      n++;
    end
    check("ready_wait", 32'(o_req_ready), 32'd1);
    i_write = w; i_addr = a; i_wdata = d; i_memsize = sz; i_req_valid = 1'b1;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_write = ~w; i_addr = ~a; i_wdata = ~d; i_memsize = ~sz;
  endtask

  // Waits for the response (expects it exactly two edges after acceptance), holds it, handshakes.
  task automatic expect_rsp(input string name, input logic [31:0] exp_data, input logic exp_err, input int hold);
    int cnt = 0;
    logic [31:0] d0;
    logic        e0;
    while (!o_rsp_valid && cnt < 10) begin
      @(posedge i_clk); #1;
      cnt++;
    end
    check({name, "_latency"}, 32'(cnt), 32'd2);
    check({name, "_data"}, o_rsp_data, exp_data);
    check({name, "_err"}, 32'(o_rsp_err), 32'(exp_err));
    check({name, "_ready_busy"}, 32'(o_req_ready), 32'd0);
    d0 = o_rsp_data;
    e0 = o_rsp_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge i_clk); #1;
      check({name, "_hold_valid"}, 32'(o_rsp_valid), 32'd1);
      check({name, "_hold_data"}, o_rsp_data, d0);
      check({name, "_hold_err"}, 32'(o_rsp_err), 32'(e0));
      check({name, "_hold_ready"}, 32'(o_req_ready), 32'd0);
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    check({name, "_post_valid"}, 32'(o_rsp_valid), 32'd0);
    check({name, "_post_data"}, o_rsp_data, 32'h0);
    check({name, "_post_err"}, 32'(o_rsp_err), 32'd0);
    check({name, "_post_ready"}, 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, SZ_WORD, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         SZ_WORD, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0013, 32'h0000_005A, SZ_BYTE, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         SZ_WORD, 32'h5AAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0013, 32'h0,         SZ_BYTE, 32'h0000_005A, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0020, 32'hCAFE_5678, SZ_WORD, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0022, 32'h0000_1234, SZ_HALF, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0020, 32'h0,         SZ_WORD, 32'h1234_5678, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0021, 32'h0,         SZ_HALF, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0020, 32'h0,         SZ_WORD, 32'h1234_5678, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0022, 32'h0,         SZ_HALF, 32'h0000_1234, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0021, 32'h0,         SZ_BYTE, 32'h0000_0056, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_0020, 32'hFFFF_FF99, SZ_BYTE, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0020, 32'h0,         SZ_WORD, 32'h1234_5699, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_1000, 32'h0,         SZ_WORD, 32'h0000_0000, 1'b1};
    vecs[15] = '{1'b1, 32'h0000_0024, 32'h1111_1111, SZ_WORD, 32'h0000_0000, 1'b0};
    vecs[16] = '{1'b1, 32'h0000_0024, 32'hFFFF_FFFF, SZ_NONE, 32'h0000_0000, 1'b1};
    vecs[17] = '{1'b0, 32'h0000_0024, 32'h0,         SZ_WORD, 32'h1111_1111, 1'b0};
    vecs[18] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_0F0F, SZ_WORD, 32'h0000_0000, 1'b0};
    vecs[19] = '{1'b0, 32'h0000_0FFC, 32'h0,         SZ_WORD, 32'hA5A5_0F0F, 1'b0};

    // Reset state while held.
    #12;
    check("rst_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_data", o_rsp_data, 32'h0);
    check("rst_err", 32'(o_rsp_err), 32'd0);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    #8 i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("rst_release_ready", 32'(o_req_ready), 32'd1);

    for (int i = 0; i < 20; i++) begin
      send(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].size);
      expect_rsp($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_err, 0);
    end

    // Backpressure with a new request waiting behind the response.
    send(1'b0, 32'h0000_0010, 32'h0, SZ_WORD);
    i_write = 1'b0; i_addr = 32'h0000_0013; i_memsize = SZ_BYTE; i_wdata = 32'h0;
    i_req_valid = 1'b1;
    expect_rsp("bp_load", 32'h5AAD_BEEF, 1'b0, 5);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    check("bp_accepted", 32'(o_req_ready), 32'd0);
    expect_rsp("bp_next", 32'h0000_005A, 1'b0, 0);

    // Reset during ACCESS of a store must suppress the write.
    send(1'b1, 32'h0000_0040, 32'h0000_0000, SZ_WORD);
    expect_rsp("zero40", 32'h0, 1'b0, 0);
    send(1'b1, 32'h0000_0040, 32'hFFFF_FFFF, SZ_WORD);
    i_rst = 1'b1;
    #1;
    check("racc_ready", 32'(o_req_ready), 32'd0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    check("racc_valid", 32'(o_rsp_valid), 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("racc_ready_back", 32'(o_req_ready), 32'd1);
    check("racc_no_rsp", 32'(o_rsp_valid), 32'd0);
    send(1'b0, 32'h0000_0040, 32'h0, SZ_WORD);
    expect_rsp("racc_load40", 32'h0000_0000, 1'b0, 0);

    // Reset during RESP drops the response.
    send(1'b0, 32'h0000_0010, 32'h0, SZ_WORD);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    check("rrsp_pre_valid", 32'(o_rsp_valid), 32'd1);
    i_rst = 1'b1;
    #1;
    check("rrsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rrsp_data", o_rsp_data, 32'h0);
    check("rrsp_err", 32'(o_rsp_err), 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("rrsp_ready", 32'(o_req_ready), 32'd1);
    send(1'b0, 32'h0000_0010, 32'h0, SZ_WORD);
    expect_rsp("rrsp_reload", 32'h5AAD_BEEF, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
